// File: rtl/m_port_ultra_point_loader_pkg.sv
// Shared definitions for the quickhull point loader.
// Contents: point/set geometry, the one-hot loader state encoding,
// the X/Y field offsets inside a point, and a slot-offset helper.
package m_port_ultra_pkg;

   localparam int unsigned PTSIZE  = 16;              // bits per point
   localparam int unsigned MAX_PTS = 256;             // points per set
   localparam int unsigned SS_W    = 9;               // set size 0..256
   localparam int unsigned PTS_W   = PTSIZE * MAX_PTS; // packed set width

   // Point fields: X in the low byte, Y in the high byte.
   localparam int unsigned PT_X_LSB = 0;
   localparam int unsigned PT_X_MSB = 7;
   localparam int unsigned PT_Y_LSB = 8;
   localparam int unsigned PT_Y_MSB = 15;

   typedef enum logic [3:0] {
      IDLE    = 4'b0001,
      LOAD    = 4'b0010,
      DRAIN   = 4'b0100,
      PUBLISH = 4'b1000
   } state_t;

   // Bit offset of slot idx inside the packed set.
   function automatic logic [11:0] slot_lsb(input logic [7:0] idx);
      return {idx, 4'b0000};
   endfunction

endpackage

// File: rtl/m_port_ultra_point_loader_if.sv
// Point-stream and packed-set bundle between producer, loader and hull core.
// slave  : loader view (takes the point stream, drives the packed set)
// master : environment view (drives the point stream, consumes the set)
// Signals: in_valid/in_ready/in_point/in_last (beat handshake),
//          points/SS/set_valid/set_ack (published set handshake).
interface m_port_ultra_point_loader_if;
   import m_port_ultra_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [PTSIZE-1:0] in_point;
   logic              in_last;
   logic [PTS_W-1:0]  points;
   logic [SS_W-1:0]   SS;
   logic              set_valid;
   logic              set_ack;

   modport slave (
      input  in_valid, in_point, in_last, set_ack,
      output in_ready, points, SS, set_valid
   );

   modport master (
      output in_valid, in_point, in_last, set_ack,
      input  in_ready, points, SS, set_valid
   );

endinterface

// File: rtl/m_port_ultra_point_loader.sv
// Quickhull point loader: packs a serial stream of 16-bit points into the
// 4096-bit point vector plus set size, then holds it until acknowledged.
// Ports:
//   CLK100MHZ   system clock
//   CPU_RESETN  asynchronous active-low reset
//   bus         point stream in / packed set out (slave modport)
//   overflow    set exceeded MAX_PTS, extra beats were dropped
//   load_count  points accepted so far in the current set
//   QIDLE/QLOAD/QDRAIN/QPUBLISH  one-hot state bits
module m_port_ultra_point_loader
   import m_port_ultra_pkg::*;
(
   input  logic                       CLK100MHZ,
   input  logic                       CPU_RESETN,
   m_port_ultra_point_loader_if.slave bus,
   output logic                       overflow,
   output logic [SS_W-1:0]            load_count,
   output logic                       QIDLE,
   output logic                       QLOAD,
   output logic                       QDRAIN,
   output logic                       QPUBLISH
);

   state_t            state_q;
   logic [PTS_W-1:0]  points_q;
   logic [SS_W-1:0]   ss_q;
   logic [SS_W-1:0]   count_q;
   logic              set_valid_q;
   logic              overflow_q;

   logic              xfer;
   logic [SS_W-1:0]   count_d;

   assign bus.in_ready = (state_q != PUBLISH);
   assign xfer         = bus.in_valid && bus.in_ready;
   assign count_d      = count_q + SS_W'(1);

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q     <= IDLE;
         points_q    <= '0;
         ss_q        <= '0;
         count_q     <= '0;
         set_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            // IDLE always sits at count 0, so it shares the LOAD slot write.
            IDLE, LOAD: begin
               if (xfer) begin
                  points_q[slot_lsb(count_q[7:0]) +: PTSIZE] <= bus.in_point;
                  count_q <= count_d;
                  if (bus.in_last) begin
                     ss_q        <= count_d;
                     set_valid_q <= 1'b1;
                     state_q     <= PUBLISH;
                  end else if (count_q == SS_W'(MAX_PTS - 1)) begin
                     overflow_q <= 1'b1;
                     state_q    <= DRAIN;
                  end else begin
                     state_q <= LOAD;
                  end
               end
            end

            DRAIN: begin
               if (xfer && bus.in_last) begin
                  ss_q        <= count_q;
                  set_valid_q <= 1'b1;
                  state_q     <= PUBLISH;
               end
            end

            PUBLISH: begin
               // SS deliberately survives the ack until the next publish.
               if (bus.set_ack) begin
                  points_q    <= '0;
                  count_q     <= '0;
                  set_valid_q <= 1'b0;
                  overflow_q  <= 1'b0;
                  state_q     <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.points    = points_q;
   assign bus.SS        = ss_q;
   assign bus.set_valid = set_valid_q;
   assign overflow      = overflow_q;
   assign load_count    = count_q;
   assign QIDLE         = state_q[0];
   assign QLOAD         = state_q[1];
   assign QDRAIN        = state_q[2];
   assign QPUBLISH      = state_q[3];

endmodule
